// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of datamem: sizes CPU requests, emits single-cycle
// memRead/memWrite pulses, does read-modify-write for sub-word stores. Optional MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 16384,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
`ifdef MISALIGN_TRAP_EN
        , ERR = 3'd5
`endif
    } state_t;

    localparam logic [29:0] IDX_MASK = 30'(MEM_WORDS - 1);

    state_t        state_q;
    logic          we_q, uns_q, done_q, mem_read_q, mem_write_q;
    logic [1:0]    sz_q, lo_q;
    logic [DW-1:0] wdata_q, rdata_q, mem_wdata_q;
    logic [31:0]   mem_addr_q;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] rdata_d, merge_d;

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    logic misalign;
    assign misalign = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // DONE is the last cycle of an access and already accepts the next request.
    assign ready       = (state_q == IDLE) || (state_q == DONE);
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign dbg_state_o = state_q;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lo_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        rdata_d = mem_rdata;
        merge_d = mem_rdata;
        case (sz_q)
            2'b00: begin
                rdata_d = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
                case (lo_q)
                    2'd1:    merge_d[15:8]  = wdata_q[7:0];
                    2'd2:    merge_d[23:16] = wdata_q[7:0];
                    2'd3:    merge_d[31:24] = wdata_q[7:0];
                    default: merge_d[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                rdata_d = {{16{half_sel[15] & ~uns_q}}, half_sel};
                if (lo_q[1]) merge_d[31:16] = wdata_q[15:0];
                else         merge_d[15:0]  = wdata_q[15:0];
            end
            default: begin
                rdata_d = mem_rdata;
                merge_d = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            sz_q        <= 2'b00;
            lo_q        <= 2'b00;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (req) begin
                        we_q    <= we;
                        uns_q   <= uns;
                        lo_q    <= addr[1:0];
                        sz_q    <= (size == 2'b11) ? 2'b10 : size;
                        wdata_q <= wdata;
`ifdef MISALIGN_TRAP_EN
                        if (misalign) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else
`endif
                        begin
                            mem_addr_q <= {2'b00, addr[31:2] & IDX_MASK};
                            if (we && size[1]) begin
                                mem_wdata_q <= wdata;
                                mem_write_q <= 1'b1;
                                state_q     <= WR;
                            end else begin
                                mem_read_q <= 1'b1;
                                state_q    <= RD;
                            end
                        end
                    end
                end
                RD: state_q <= CAP;
                CAP: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_d;
                        mem_write_q <= 1'b1;
                        state_q     <= WR;
                    end else begin
                        rdata_q <= rdata_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WR: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
`ifdef MISALIGN_TRAP_EN
                ERR: state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a negedge datamem model and strobe monitor.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  dbg_state;

    logic [31:0] mem [0:16383];
    logic [31:0] exp_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int overlap_cnt = 0, dbl_cnt = 0;
    int rd_cyc = 0, wr_cyc = 0, done_cyc = 0, acc = 0;
    logic [31:0] rd_addr = 0, wr_addr = 0, wr_data = 0, done_rdata = 0;
    logic prev_rd = 0, prev_wr = 0, prev_done = 0;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
        .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // datamem model and strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_read && mem_write) overlap_cnt++;
        if ((mem_read && prev_rd) || (mem_write && prev_wr) || (done && prev_done)) dbl_cnt++;
        prev_rd = mem_read;
        prev_wr = mem_write;
        prev_done = done;
        if (mem_read) begin
            rd_cnt++; rd_cyc = cyc; rd_addr = mem_addr;
            mem_rdata = mem[mem_addr[13:0]];
        end
        if (mem_write) begin
            wr_cnt++; wr_cyc = cyc; wr_addr = mem_addr; wr_data = mem_wdata;
            mem[mem_addr[13:0]] = mem_wdata;
        end
        if (done) begin
            done_cnt++; done_cyc = cyc; done_rdata = rdata;
        end
        if (err) err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected < 100000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one request at the first negedge where ready is high
    task automatic issue(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        int budget = 0;
        @(negedge clk);
        while (!ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("ready_before_issue", 32'(ready), 32'd1);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        acc = cyc;
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFC; wdata = ~d; uns = ~u;
    endtask

    task automatic wait_ev(input int target);
        int budget = 0;
        while ((done_cnt + err_cnt) < target && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check("completion_timeout", 32'((done_cnt + err_cnt) >= target), 32'd1);
    endtask

    task automatic run(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        int ev0 = done_cnt + err_cnt;
        issue(w, s, u, a, d);
        wait_ev(ev0 + 1);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] s, input logic u,
                            input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        run(1'b0, s, u, a, 32'h0);
        check(tag, done_rdata, exp_q.pop_front());
    endtask

    initial begin
        int r0, w0, d0, e0, a1, a2;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

        // reset
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // word store then word load
        r0 = rd_cnt;
        run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("ws_addr", wr_addr, 32'd4);
        check("ws_data", wr_data, 32'hDEADBEEF);
        check("ws_write_cyc", 32'(wr_cyc - acc), 32'd0);
        check("ws_done_cyc", 32'(done_cyc - acc), 32'd1);
        check("ws_no_read", 32'(rd_cnt - r0), 32'd0);
        check("ws_mem", mem[4], 32'hDEADBEEF);
        load_chk("wl_rdata", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("wl_read_cyc", 32'(rd_cyc - acc), 32'd0);
        check("wl_done_cyc", 32'(done_cyc - acc), 32'd2);
        check("wl_rd_addr", rd_addr, 32'd4);
        check("wl_rdata_held", rdata, 32'hDEADBEEF);

        // byte store read-modify-write and byte loads
        mem[4] = 32'h11223344;
        run(1'b1, 2'b00, 1'b0, 32'h13, 32'h5A5A5AA5);
        check("bs_read_cyc", 32'(rd_cyc - acc), 32'd0);
        check("bs_write_cyc", 32'(wr_cyc - acc), 32'd2);
        check("bs_done_cyc", 32'(done_cyc - acc), 32'd3);
        check("bs_wdata", wr_data, 32'hA5223344);
        load_chk("bl_signed", 2'b00, 1'b0, 32'h13, 32'hFFFFFFA5);
        load_chk("bl_unsigned", 2'b00, 1'b1, 32'h13, 32'h000000A5);
        load_chk("bl_lane1", 2'b00, 1'b0, 32'h11, 32'h00000033);

        // halfword loads and store
        mem[4] = 32'h80017FFF;
        load_chk("hl_hi_signed", 2'b01, 1'b0, 32'h12, 32'hFFFF8001);
        load_chk("hl_lo_signed", 2'b01, 1'b0, 32'h10, 32'h00007FFF);
        load_chk("hl_hi_unsigned", 2'b01, 1'b1, 32'h12, 32'h00008001);
        run(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
        check("hs_wdata", wr_data, 32'hBEEF7FFF);

        // req while busy is ignored
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("busy_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_one_read", 32'(rd_cnt - r0), 32'd1);
        check("busy_no_write", 32'(wr_cnt - w0), 32'd0);
        check("busy_rdata", done_rdata, 32'hBEEF7FFF);
        check("busy_mem8", mem[8], 32'h0);

        // reset during WR
        d0 = done_cnt; w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h55AA55AA);
        check("rw_write_high", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rw_write_cut", 32'(mem_write), 32'd0);
        check("rw_done_low", 32'(done), 32'd0);
        check("rw_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rw_no_done", 32'(done_cnt - d0), 32'd0);
        check("rw_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rw_ready_after", 32'(ready), 32'd1);

        // address wrap
        run(1'b1, 2'b10, 1'b0, 32'h0001_0008, 32'h12345678);
        check("wrap_addr", wr_addr, 32'd2);
        check("wrap_mem", mem[2], 32'h12345678);
        load_chk("wrap_load", 2'b10, 1'b0, 32'h0001_0008, 32'h12345678);

        // misalignment and size=11
        mem[1] = 32'hCAFEF00D;
`ifdef MISALIGN_TRAP_EN
        e0 = err_cnt; r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        run(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        run(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
        run(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        run(1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFFFFFF);
        check("trap_err_count", 32'(err_cnt - e0), 32'd4);
        check("trap_no_read", 32'(rd_cnt - r0), 32'd0);
        check("trap_no_write", 32'(wr_cnt - w0), 32'd0);
        check("trap_no_done", 32'(done_cnt - d0), 32'd0);
        check("trap_rdata", rdata, 32'h12345678);
        check("trap_mem1", mem[1], 32'hCAFEF00D);
`else
        load_chk("mis_word", 2'b10, 1'b0, 32'h6, 32'hCAFEF00D);
        check("mis_word_addr", rd_addr, 32'd1);
        load_chk("size11_word", 2'b11, 1'b1, 32'h8, 32'h12345678);
        load_chk("mis_half", 2'b01, 1'b0, 32'h13, 32'hFFFFBEEF);
        check("no_err", 32'(err_cnt), 32'd0);
`endif

        // back-to-back spacing
        d0 = done_cnt + err_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000AAAA); a1 = acc;
        issue(1'b1, 2'b10, 1'b0, 32'h34, 32'h0000BBBB); a2 = acc;
        wait_ev(d0 + 2);
        check("b2b_store_spacing", 32'(a2 - a1), 32'd2);
        check("b2b_mem12", mem[12], 32'h0000AAAA);
        check("b2b_mem13", mem[13], 32'h0000BBBB);
        d0 = done_cnt + err_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0); a1 = acc;
        issue(1'b0, 2'b10, 1'b0, 32'h34, 32'h0); a2 = acc;
        wait_ev(d0 + 2);
        check("b2b_load_spacing", 32'(a2 - a1), 32'd3);
        check("b2b_load_rdata", done_rdata, 32'h0000BBBB);
        d0 = done_cnt + err_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h00000011); a1 = acc;
        issue(1'b1, 2'b00, 1'b0, 32'h32, 32'h00000022); a2 = acc;
        wait_ev(d0 + 2);
        check("b2b_sub_spacing", 32'(a2 - a1), 32'd4);
        check("b2b_sub_mem12", mem[12], 32'h002211AA);

        // random traffic: strobe exclusivity and single-cycle pulses
        d0 = done_cnt + err_cnt;
        for (int i = 0; i < 200; i++) begin
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom());
        end
        check("rand_completions", 32'(done_cnt + err_cnt - d0), 32'd200);
        check("rand_no_overlap", 32'(overlap_cnt), 32'd0);
        check("rand_single_cycle", 32'(dbl_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
